// File: rtl/control_to_network_bridge_arbiter.sv
// Packet-level round-robin arbiter merging the ANC and NAC AXIS streams onto the single
// network-bridge egress path through one registered output stage.
module control_to_network_bridge_arbiter #(
  parameter int AXIS_DATA_WIDTH          = 64,
  parameter int AXIS_KEEP_WIDTH          = 8,
  parameter int AXIS_FROM_NB_TDEST_WIDTH = 8,
  parameter int AXIS_FROM_NB_TUSER_WIDTH = 16
) (
  input  logic                                i_clk,
  input  logic                                i_ap_rst,

  input  logic                                from_anc_tvalid,
  output logic                                from_anc_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]          from_anc_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]          from_anc_tkeep,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_anc_tid,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_anc_tdest,
  input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_anc_tuser,
  input  logic                                from_anc_tlast,

  input  logic                                from_nac_tvalid,
  output logic                                from_nac_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]          from_nac_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]          from_nac_tkeep,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_nac_tid,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_nac_tdest,
  input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_nac_tuser,
  input  logic                                from_nac_tlast,

  output logic                                to_network_bridge_tvalid,
  input  logic                                to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]          to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]          to_network_bridge_tkeep,
  output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_network_bridge_tid,
  output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_network_bridge_tdest,
  output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                                to_network_bridge_tlast,

  output logic [1:0]                          dbg_state,
  output logic                                dbg_last_grant
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT_ANC = 2'd1;
  localparam logic [1:0] ST_GRANT_NAC = 2'd2;

  logic [1:0] state;
  logic       last_grant;  // 0 = ANC, 1 = NAC
  logic       out_ready;
  logic       anc_fire;
  logic       nac_fire;

  // A beat moves on any interface exactly when tvalid & tready are both high at a rising
  // edge; tvalid never waits on tready, and the output holds its beat until it is taken.
  assign out_ready       = !to_network_bridge_tvalid || to_network_bridge_tready;
  assign from_anc_tready = (state == ST_GRANT_ANC) && out_ready;
  assign from_nac_tready = (state == ST_GRANT_NAC) && out_ready;
  assign anc_fire        = from_anc_tvalid && from_anc_tready;
  assign nac_fire        = from_nac_tvalid && from_nac_tready;

  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          // On a tie the requester that did not own the previous packet wins.
          if (from_anc_tvalid && from_nac_tvalid)
            state <= last_grant ? ST_GRANT_ANC : ST_GRANT_NAC;
          else if (from_anc_tvalid)
            state <= ST_GRANT_ANC;
          else if (from_nac_tvalid)
            state <= ST_GRANT_NAC;
        end
        ST_GRANT_ANC: begin
          if (anc_fire && from_anc_tlast) begin
            state      <= ST_IDLE;
            last_grant <= 1'b0;
          end
        end
        ST_GRANT_NAC: begin
          if (nac_fire && from_nac_tlast) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      to_network_bridge_tvalid <= 1'b0;
      to_network_bridge_tdata  <= '0;
      to_network_bridge_tkeep  <= '0;
      to_network_bridge_tid    <= '0;
      to_network_bridge_tdest  <= '0;
      to_network_bridge_tuser  <= '0;
      to_network_bridge_tlast  <= 1'b0;
    end else if (anc_fire) begin
      to_network_bridge_tvalid <= 1'b1;
      to_network_bridge_tdata  <= from_anc_tdata;
      to_network_bridge_tkeep  <= from_anc_tkeep;
      to_network_bridge_tid    <= from_anc_tid;
      to_network_bridge_tdest  <= from_anc_tdest;
      to_network_bridge_tuser  <= from_anc_tuser;
      to_network_bridge_tlast  <= from_anc_tlast;
    end else if (nac_fire) begin
      to_network_bridge_tvalid <= 1'b1;
      to_network_bridge_tdata  <= from_nac_tdata;
      to_network_bridge_tkeep  <= from_nac_tkeep;
      to_network_bridge_tid    <= from_nac_tid;
      to_network_bridge_tdest  <= from_nac_tdest;
      to_network_bridge_tuser  <= from_nac_tuser;
      to_network_bridge_tlast  <= from_nac_tlast;
    end else if (out_ready) begin
      to_network_bridge_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_control_to_network_bridge_arbiter.sv
// Directed bench for control_to_network_bridge_arbiter: per-cycle vector table for the
// packet scenarios, hand sequences for mid-packet reset and alternating single-beat packets.
module tb_control_to_network_bridge_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TW = 8;
  localparam int UW = 16;
  localparam int BW = DW + KW + TW + TW + UW + 1;

  logic          i_clk = 1'b0;
  logic          i_ap_rst;
  logic          anc_valid, nac_valid, out_tready;
  logic [BW-1:0] anc_beat, nac_beat;

  logic          from_anc_tready, from_nac_tready;
  logic [DW-1:0] from_anc_tdata, from_nac_tdata, to_network_bridge_tdata;
  logic [KW-1:0] from_anc_tkeep, from_nac_tkeep, to_network_bridge_tkeep;
  logic [TW-1:0] from_anc_tid, from_nac_tid, to_network_bridge_tid;
  logic [TW-1:0] from_anc_tdest, from_nac_tdest, to_network_bridge_tdest;
  logic [UW-1:0] from_anc_tuser, from_nac_tuser, to_network_bridge_tuser;
  logic          from_anc_tlast, from_nac_tlast, to_network_bridge_tlast;
  logic          to_network_bridge_tvalid;
  logic [1:0]    dbg_state;
  logic          dbg_last_grant;
  logic [BW-1:0] out_beat;

  assign {from_anc_tdata, from_anc_tkeep, from_anc_tid, from_anc_tdest, from_anc_tuser, from_anc_tlast} = anc_beat;
  assign {from_nac_tdata, from_nac_tkeep, from_nac_tid, from_nac_tdest, from_nac_tuser, from_nac_tlast} = nac_beat;
  assign out_beat = {to_network_bridge_tdata, to_network_bridge_tkeep, to_network_bridge_tid,
                     to_network_bridge_tdest, to_network_bridge_tuser, to_network_bridge_tlast};

  control_to_network_bridge_arbiter #(
    .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
    .AXIS_FROM_NB_TDEST_WIDTH(TW), .AXIS_FROM_NB_TUSER_WIDTH(UW)
  ) dut (
    .i_clk(i_clk), .i_ap_rst(i_ap_rst),
    .from_anc_tvalid(anc_valid), .from_anc_tready(from_anc_tready),
    .from_anc_tdata(from_anc_tdata), .from_anc_tkeep(from_anc_tkeep),
    .from_anc_tid(from_anc_tid), .from_anc_tdest(from_anc_tdest),
    .from_anc_tuser(from_anc_tuser), .from_anc_tlast(from_anc_tlast),
    .from_nac_tvalid(nac_valid), .from_nac_tready(from_nac_tready),
    .from_nac_tdata(from_nac_tdata), .from_nac_tkeep(from_nac_tkeep),
    .from_nac_tid(from_nac_tid), .from_nac_tdest(from_nac_tdest),
    .from_nac_tuser(from_nac_tuser), .from_nac_tlast(from_nac_tlast),
    .to_network_bridge_tvalid(to_network_bridge_tvalid),
    .to_network_bridge_tready(out_tready),
    .to_network_bridge_tdata(to_network_bridge_tdata),
    .to_network_bridge_tkeep(to_network_bridge_tkeep),
    .to_network_bridge_tid(to_network_bridge_tid),
    .to_network_bridge_tdest(to_network_bridge_tdest),
    .to_network_bridge_tuser(to_network_bridge_tuser),
    .to_network_bridge_tlast(to_network_bridge_tlast),
    .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int            checks = 0;
  int            failures = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] anc_q[$];
  logic [BW-1:0] nac_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // one beat of the table scenarios: data byte replicated, sideband fixed per source
  function automatic logic [BW-1:0] tbeat(input logic [7:0] d, input logic is_nac, input logic l);
    return {{8{d}}, is_nac ? 8'h0F : 8'hFF, is_nac ? 8'h03 : 8'h01,
            is_nac ? 8'h04 : 8'h02, is_nac ? 16'h00C0 : 16'h00A0, l};
  endfunction

  function automatic logic [BW-1:0] mkbeat(input logic is_nac, input int i);
    logic [31:0] idx;
    logic [7:0]  k;
    idx = i;
    k   = 8'(i * 37 + (is_nac ? 11 : 0));
    return {(is_nac ? 32'hC0DE0000 : 32'hA0DE0000) | idx, 32'h0BADF00D ^ idx, k,
            {is_nac, idx[6:0]}, 8'h80 ^ idx[7:0], {is_nac ? 8'hCC : 8'hAA, idx[7:0]}, 1'b1};
  endfunction

  typedef struct packed {
    logic       rst;
    logic       av;
    logic [7:0] ad;
    logic       al;
    logic       nv;
    logic [7:0] nd;
    logic       nl;
    logic       tr;
    logic       e_atr;
    logic       e_ntr;
    logic       e_v;
    logic [7:0] e_d;
    logic       e_l;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rst, av, input logic [7:0] ad, input logic al,
                              input logic nv, input logic [7:0] nd, input logic nl, input logic tr,
                              input logic e_atr, e_ntr, e_v, input logic [7:0] e_d, input logic e_l);
    vec_t v;
    v = '{rst, av, ad, al, nv, nd, nl, tr, e_atr, e_ntr, e_v, e_d, e_l};
    return v;
  endfunction

  initial begin
    int cyc;
    i_ap_rst   = 1'b1;
    anc_valid  = 1'b0;
    nac_valid  = 1'b0;
    out_tready = 1'b1;
    anc_beat   = '0;
    nac_beat   = '0;

    // ANC-only 3-beat packet
    vt.push_back(mk(0,1,8'hA1,0, 0,8'h00,0, 1, 0,0,0,8'h00,0));
    vt.push_back(mk(0,1,8'hA1,0, 0,8'h00,0, 1, 1,0,0,8'h00,0));
    vt.push_back(mk(0,1,8'hA2,0, 0,8'h00,0, 1, 1,0,1,8'hA1,0));
    vt.push_back(mk(0,1,8'hA3,1, 0,8'h00,0, 1, 1,0,1,8'hA2,0));
    vt.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,0,1,8'hA3,1));
    vt.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,0,0,8'h00,0));
    // reset, then simultaneous requests: ANC 2 beats, NAC 1 beat, then another tie
    vt.push_back(mk(1,0,8'h00,0, 0,8'h00,0, 1, 0,0,0,8'h00,0));
    vt.push_back(mk(0,1,8'hB1,0, 1,8'hC1,1, 1, 0,0,0,8'h00,0));
    vt.push_back(mk(0,1,8'hB1,0, 1,8'hC1,1, 1, 1,0,0,8'h00,0));
    vt.push_back(mk(0,1,8'hB2,1, 1,8'hC1,1, 1, 1,0,1,8'hB1,0));
    vt.push_back(mk(0,0,8'h00,0, 1,8'hC1,1, 1, 0,0,1,8'hB2,1));
    vt.push_back(mk(0,0,8'h00,0, 1,8'hC1,1, 1, 0,1,0,8'h00,0));
    vt.push_back(mk(0,1,8'hD1,1, 1,8'hE1,1, 1, 0,0,1,8'hC1,1));
    vt.push_back(mk(0,1,8'hD1,1, 1,8'hE1,1, 1, 1,0,0,8'h00,0));
    vt.push_back(mk(0,0,8'h00,0, 1,8'hE1,1, 1, 0,0,1,8'hD1,1));
    vt.push_back(mk(0,0,8'h00,0, 1,8'hE1,1, 1, 0,1,0,8'h00,0));
    vt.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,0,1,8'hE1,1));
    vt.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,0,0,8'h00,0));
    // NAC 4-beat packet, ANC requests at beat 2 and must wait
    vt.push_back(mk(0,0,8'h00,0, 1,8'hF1,0, 1, 0,0,0,8'h00,0));
    vt.push_back(mk(0,0,8'h00,0, 1,8'hF1,0, 1, 0,1,0,8'h00,0));
    vt.push_back(mk(0,1,8'h61,1, 1,8'hF2,0, 1, 0,1,1,8'hF1,0));
    vt.push_back(mk(0,1,8'h61,1, 1,8'hF3,0, 1, 0,1,1,8'hF2,0));
    vt.push_back(mk(0,1,8'h61,1, 1,8'hF4,1, 1, 0,1,1,8'hF3,0));
    vt.push_back(mk(0,1,8'h61,1, 0,8'h00,0, 1, 0,0,1,8'hF4,1));
    vt.push_back(mk(0,1,8'h61,1, 0,8'h00,0, 1, 1,0,0,8'h00,0));
    vt.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,0,1,8'h61,1));
    vt.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,0,0,8'h00,0));
    // ANC 4-beat packet with the bridge stalling five cycles after the first beat
    vt.push_back(mk(0,1,8'h71,0, 0,8'h00,0, 1, 0,0,0,8'h00,0));
    vt.push_back(mk(0,1,8'h71,0, 0,8'h00,0, 1, 1,0,0,8'h00,0));
    for (int s = 0; s < 5; s++)
      vt.push_back(mk(0,1,8'h72,0, 0,8'h00,0, 0, 0,0,1,8'h71,0));
    vt.push_back(mk(0,1,8'h72,0, 0,8'h00,0, 1, 1,0,1,8'h71,0));
    vt.push_back(mk(0,1,8'h73,0, 0,8'h00,0, 1, 1,0,1,8'h72,0));
    vt.push_back(mk(0,1,8'h74,1, 0,8'h00,0, 1, 1,0,1,8'h73,0));
    vt.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,0,1,8'h74,1));
    vt.push_back(mk(0,0,8'h00,0, 0,8'h00,0, 1, 0,0,0,8'h00,0));

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_ap_rst = 1'b0;
    #1;
    chk("rst_tvalid", 128'(to_network_bridge_tvalid), 128'd0);
    chk("rst_beat", 128'(out_beat), 128'd0);
    chk("rst_state", 128'(dbg_state), 128'd0);
    chk("rst_last_grant", 128'(dbg_last_grant), 128'd1);
    chk("rst_readies", 128'({from_anc_tready, from_nac_tready}), 128'd0);

    // table: inputs for this cycle, observed readies and the output register of this cycle
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge i_clk);
      i_ap_rst   = vt[i].rst;
      anc_valid  = vt[i].av;
      anc_beat   = tbeat(vt[i].ad, 1'b0, vt[i].al);
      nac_valid  = vt[i].nv;
      nac_beat   = tbeat(vt[i].nd, 1'b1, vt[i].nl);
      out_tready = vt[i].tr;
      #1;
      chk($sformatf("row%0d_anc_tready", i), 128'(from_anc_tready), 128'(vt[i].e_atr));
      chk($sformatf("row%0d_nac_tready", i), 128'(from_nac_tready), 128'(vt[i].e_ntr));
      chk($sformatf("row%0d_tvalid", i), 128'(to_network_bridge_tvalid), 128'(vt[i].e_v));
      if (vt[i].e_v) begin
        chk($sformatf("row%0d_tdata", i), 128'(to_network_bridge_tdata), 128'({8{vt[i].e_d}}));
        chk($sformatf("row%0d_tlast", i), 128'(to_network_bridge_tlast), 128'(vt[i].e_l));
      end
    end

    // reset in the middle of a 4-beat ANC packet
    @(negedge i_clk);
    i_ap_rst = 1'b0; out_tready = 1'b1; nac_valid = 1'b0;
    anc_valid = 1'b1; anc_beat = tbeat(8'h91, 1'b0, 1'b0);
    #1 chk("mr_idle_ready", 128'(from_anc_tready), 128'd0);
    @(negedge i_clk);
    #1 chk("mr_grant_ready", 128'(from_anc_tready), 128'd1);
    @(negedge i_clk);
    anc_beat = tbeat(8'h92, 1'b0, 1'b0);
    #1 chk("mr_beat1", 128'(out_beat), 128'(tbeat(8'h91, 1'b0, 1'b0)));
    @(negedge i_clk);
    anc_beat = tbeat(8'h93, 1'b0, 1'b0);
    i_ap_rst = 1'b1;
    #1 chk("mr_beat2", 128'(out_beat), 128'(tbeat(8'h92, 1'b0, 1'b0)));
    @(negedge i_clk);
    i_ap_rst = 1'b0;
    anc_beat = tbeat(8'h95, 1'b0, 1'b1);
    nac_valid = 1'b1; nac_beat = tbeat(8'h96, 1'b1, 1'b1);
    #1;
    chk("mr_tvalid", 128'(to_network_bridge_tvalid), 128'd0);
    chk("mr_beat_clear", 128'(out_beat), 128'd0);
    chk("mr_state", 128'(dbg_state), 128'd0);
    chk("mr_last_grant", 128'(dbg_last_grant), 128'd1);
    @(negedge i_clk);
    #1 chk("mr_tie_readies", 128'({from_anc_tready, from_nac_tready}), 128'b10);
    @(negedge i_clk);
    anc_valid = 1'b0;
    #1 chk("mr_anc_out", 128'(out_beat), 128'(tbeat(8'h95, 1'b0, 1'b1)));
    chk("mr_anc_tvalid", 128'(to_network_bridge_tvalid), 128'd1);
    @(negedge i_clk);
    #1 chk("mr_nac_ready", 128'(from_nac_tready), 128'd1);
    @(negedge i_clk);
    nac_valid = 1'b0;
    #1 chk("mr_nac_out", 128'(out_beat), 128'(tbeat(8'h96, 1'b1, 1'b1)));
    @(negedge i_clk);
    #1 chk("mr_drain", 128'(to_network_bridge_tvalid), 128'd0);

    // 20 single-beat packets from each side, both always requesting: strict alternation
    for (int i = 0; i < 20; i++) begin
      anc_q.push_back(mkbeat(1'b0, i));
      nac_q.push_back(mkbeat(1'b1, i));
      exp_q.push_back(mkbeat(1'b0, i));
      exp_q.push_back(mkbeat(1'b1, i));
    end
    cyc = 0;
    while ((anc_q.size() != 0 || nac_q.size() != 0 || exp_q.size() != 0) && cyc < 300) begin
      @(negedge i_clk);
      anc_valid = (anc_q.size() != 0);
      if (anc_valid) anc_beat = anc_q[0];
      nac_valid = (nac_q.size() != 0);
      if (nac_valid) nac_beat = nac_q[0];
      #1;
      if (from_anc_tready && from_nac_tready)
        chk("alt_both_ready", 128'd1, 128'd0);
      if (to_network_bridge_tvalid) begin
        if (exp_q.size() == 0) chk("alt_extra_beat", 128'(out_beat), 128'd0);
        else chk($sformatf("alt_beat%0d", 40 - exp_q.size()), 128'(out_beat), 128'(exp_q.pop_front()));
      end
      if (anc_valid && from_anc_tready) void'(anc_q.pop_front());
      if (nac_valid && from_nac_tready) void'(nac_q.pop_front());
      cyc++;
    end
    chk("alt_missing_beats", 128'(exp_q.size()), 128'd0);
    @(negedge i_clk);
    anc_valid = 1'b0; nac_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
